// File: rtl/punc_control_pkg.sv
// Shared PUnC constants: opcodes, control FSM state encoding and every
// datapath select encoding. Imported by the control unit and the datapath.
package punc_control_pkg;

    localparam int unsigned IR_W     = 16;
    localparam int unsigned OPCODE_W = 4;

    // Opcodes (ir[15:12])
    localparam logic [OPCODE_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_LD   = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_RSV8 = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OPCODE_W-1:0] OP_RSVD = 4'b1101;
    localparam logic [OPCODE_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'b1111;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXECUTE  = 3'd3,
        ST_EXECUTE2 = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    // Memory read address
    localparam logic [1:0] MEM_R_ADDR_SEL_PC    = 2'd0;
    localparam logic [1:0] MEM_R_ADDR_SEL_PC9   = 2'd1;
    localparam logic [1:0] MEM_R_ADDR_SEL_R0OFF = 2'd2;
    localparam logic [1:0] MEM_R_ADDR_SEL_TMP   = 2'd3;

    // Memory write address
    localparam logic [1:0] MEM_W_ADDR_SEL_PC9   = 2'd0;
    localparam logic [1:0] MEM_W_ADDR_SEL_R0OFF = 2'd1;
    localparam logic [1:0] MEM_W_ADDR_SEL_TMP   = 2'd2;

    // Register file selects
    localparam logic       RF_R1_ADDR_SEL_IR20  = 1'b0;
    localparam logic       RF_R1_ADDR_SEL_IR119 = 1'b1;
    localparam logic       RF_W_ADDR_SEL_IR119  = 1'b0;
    localparam logic       RF_W_ADDR_SEL_R7     = 1'b1;
    localparam logic [1:0] RF_W_DATA_SEL_ALU    = 2'd0;
    localparam logic [1:0] RF_W_DATA_SEL_MEM    = 2'd1;
    localparam logic [1:0] RF_W_DATA_SEL_PC     = 2'd2;
    localparam logic [1:0] RF_W_DATA_SEL_PC9    = 2'd3;

    // PC load source
    localparam logic [1:0] PC_LD_DATA_SEL_PC9  = 2'd0;
    localparam logic [1:0] PC_LD_DATA_SEL_R0   = 2'd1;
    localparam logic [1:0] PC_LD_DATA_SEL_PC11 = 2'd2;

    // ALU functions
    localparam logic [2:0] ALU_FN_ADD  = 3'd0;
    localparam logic [2:0] ALU_FN_ADDI = 3'd1;
    localparam logic [2:0] ALU_FN_AND  = 3'd2;
    localparam logic [2:0] ALU_FN_ANDI = 3'd3;
    localparam logic [2:0] ALU_FN_NOT  = 3'd4;
    localparam logic [2:0] ALU_FN_PASS = 3'd5;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [IR_W-1:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/punc_br_eval.sv
// Branch condition evaluation: taken when any requested flag (ir[11:9] = n,z,p)
// is currently set. A mask of 000 is never taken.
// Ports: nzp_mask (ir[11:9]), n/z/p flags in; taken_c combinational out.
module punc_br_eval (
    input  logic [2:0] nzp_mask,
    input  logic       n,
    input  logic       z,
    input  logic       p,
    output logic       taken_c
);

    assign taken_c = (nzp_mask[2] & n) | (nzp_mask[1] & z) | (nzp_mask[0] & p);

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 multicycle control FSM. Sequences INIT -> FETCH -> DECODE ->
// EXECUTE (-> EXECUTE2) until HALT and drives every datapath strobe/select
// as a combinational decode of state and ir (forced to 0 while rst is high).
// Ports: clk, rst (async, active high), ir[15:0], n/z/p flags in;
//        memory, register file, IR/TMP/PC, ALU and cond strobes out; halted.
// Optional: PUNC_INSTR_CNT_EN adds instr_retired[31:0], a retired-instruction
//           counter (HALT not counted, frozen once halted).
module punc_control
    import punc_control_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] ir,
    input  logic            n,
    input  logic            z,
    input  logic            p,
    output logic            mem_w_en,
    output logic [1:0]      mem_r_addr_sel,
    output logic [1:0]      mem_w_addr_sel,
    output logic            rf_w_en,
    output logic            rf_r1_addr_sel,
    output logic            rf_w_addr_sel,
    output logic [1:0]      rf_w_data_sel,
    output logic            ir_ld,
    output logic            tmp_ld,
    output logic            pc_ld,
    output logic            pc_clr,
    output logic            pc_inc,
    output logic [1:0]      pc_ld_data_sel,
    output logic [2:0]      alu_sel,
    output logic            cond_ld,
    output logic            halted
`ifdef PUNC_INSTR_CNT_EN
    ,
    output logic [31:0]     instr_retired
`endif
);

    state_t               state;
    state_t               state_nxt;
    logic [OPCODE_W-1:0]  opcode;
    logic                 br_taken;
    logic                 unused_ir;

    assign opcode    = opcode_of(ir);
    assign unused_ir = ^{ir[8:6], ir[4:0]};

    punc_br_eval u_br_eval (
        .nzp_mask (ir[11:9]),
        .n        (n),
        .z        (z),
        .p        (p),
        .taken_c  (br_taken)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:     state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_DECODE;
            ST_DECODE:   state_nxt = (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:  state_nxt = (opcode == OP_LDI || opcode == OP_STI) ? ST_EXECUTE2 : ST_FETCH;
            ST_EXECUTE2: state_nxt = ST_FETCH;
            ST_HALT:     state_nxt = ST_HALT;
            default:     state_nxt = ST_INIT;
        endcase
    end

    // Output decode; everything defaults to 0 and is held at 0 during reset
    always_comb begin
        mem_w_en       = 1'b0;
        mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
        mem_w_addr_sel = MEM_W_ADDR_SEL_PC9;
        rf_w_en        = 1'b0;
        rf_r1_addr_sel = RF_R1_ADDR_SEL_IR20;
        rf_w_addr_sel  = RF_W_ADDR_SEL_IR119;
        rf_w_data_sel  = RF_W_DATA_SEL_ALU;
        ir_ld          = 1'b0;
        tmp_ld         = 1'b0;
        pc_ld          = 1'b0;
        pc_clr         = 1'b0;
        pc_inc         = 1'b0;
        pc_ld_data_sel = PC_LD_DATA_SEL_PC9;
        alu_sel        = ALU_FN_ADD;
        cond_ld        = 1'b0;
        halted         = 1'b0;
        if (!rst) begin
            case (state)
                ST_INIT: pc_clr = 1'b1;
                ST_FETCH: begin
                    mem_r_addr_sel = MEM_R_ADDR_SEL_PC;
                    ir_ld          = 1'b1;
                    pc_inc         = 1'b1;
                end
                ST_EXECUTE: begin
                    case (opcode)
                        OP_ADD, OP_AND: begin
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                            if (opcode == OP_ADD) alu_sel = ir[5] ? ALU_FN_ADDI : ALU_FN_ADD;
                            else                  alu_sel = ir[5] ? ALU_FN_ANDI : ALU_FN_AND;
                        end
                        OP_NOT: begin
                            alu_sel = ALU_FN_NOT;
                            rf_w_en = 1'b1;
                            cond_ld = 1'b1;
                        end
                        OP_BR: begin
                            pc_ld          = br_taken;
                            pc_ld_data_sel = PC_LD_DATA_SEL_PC9;
                        end
                        OP_JMP: begin
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = PC_LD_DATA_SEL_R0;
                        end
                        OP_JSR: begin
                            // R7 captures the old PC while PC loads; JSRR R7 reads R7 before the write lands
                            rf_w_en        = 1'b1;
                            rf_w_addr_sel  = RF_W_ADDR_SEL_R7;
                            rf_w_data_sel  = RF_W_DATA_SEL_PC;
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = ir[11] ? PC_LD_DATA_SEL_PC11 : PC_LD_DATA_SEL_R0;
                        end
                        OP_LD: begin
                            mem_r_addr_sel = MEM_R_ADDR_SEL_PC9;
                            rf_w_data_sel  = RF_W_DATA_SEL_MEM;
                            rf_w_en        = 1'b1;
                            cond_ld        = 1'b1;
                        end
                        OP_LDR: begin
                            mem_r_addr_sel = MEM_R_ADDR_SEL_R0OFF;
                            rf_w_data_sel  = RF_W_DATA_SEL_MEM;
                            rf_w_en        = 1'b1;
                            cond_ld        = 1'b1;
                        end
                        OP_LEA: begin
                            rf_w_data_sel = RF_W_DATA_SEL_PC9;
                            rf_w_en       = 1'b1;
                            cond_ld       = 1'b1;
                        end
                        OP_ST, OP_STR: begin
                            mem_w_en       = 1'b1;
                            rf_r1_addr_sel = RF_R1_ADDR_SEL_IR119;
                            mem_w_addr_sel = (opcode == OP_ST) ? MEM_W_ADDR_SEL_PC9 : MEM_W_ADDR_SEL_R0OFF;
                        end
                        OP_LDI, OP_STI: begin
                            // First hop: fetch the pointer into TMP
                            mem_r_addr_sel = MEM_R_ADDR_SEL_PC9;
                            tmp_ld         = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EXECUTE2: begin
                    if (opcode == OP_LDI) begin
                        mem_r_addr_sel = MEM_R_ADDR_SEL_TMP;
                        rf_w_data_sel  = RF_W_DATA_SEL_MEM;
                        rf_w_en        = 1'b1;
                        cond_ld        = 1'b1;
                    end else if (opcode == OP_STI) begin
                        mem_w_addr_sel = MEM_W_ADDR_SEL_TMP;
                        mem_w_en       = 1'b1;
                        rf_r1_addr_sel = RF_R1_ADDR_SEL_IR119;
                    end
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PUNC_INSTR_CNT_EN
    // Retired-instruction counter: one count per return to FETCH from execution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_retired <= 32'd0;
        end else if (state_nxt == ST_FETCH &&
                     (state == ST_EXECUTE || state == ST_EXECUTE2)) begin
            instr_retired <= instr_retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: the stimulus process pushes the
// hand-computed expected strobe vector for each cycle, the monitor pops and
// compares against the DUT outputs on the falling edge (or on demand).
module tb_punc_control;

    typedef struct packed {
        logic       mem_w_en;
        logic [1:0] mem_r_addr_sel;
        logic [1:0] mem_w_addr_sel;
        logic       rf_w_en;
        logic       rf_r1_addr_sel;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       ir_ld;
        logic       tmp_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       halted;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  e;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        n, z, p;
    logic        mem_w_en, rf_w_en, rf_r1_addr_sel, rf_w_addr_sel;
    logic        ir_ld, tmp_ld, pc_ld, pc_clr, pc_inc, cond_ld, halted;
    logic [1:0]  mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, pc_ld_data_sel;
    logic [2:0]  alu_sel;
`ifdef PUNC_INSTR_CNT_EN
    logic [31:0] instr_retired;
`endif

    exp_t  act;
    item_t sb[$];
    event  sample_ev;
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_retired = 0;

    always #5 clk = ~clk;

    punc_control dut (
        .clk            (clk),
        .rst            (rst),
        .ir             (ir),
        .n              (n),
        .z              (z),
        .p              (p),
        .mem_w_en       (mem_w_en),
        .mem_r_addr_sel (mem_r_addr_sel),
        .mem_w_addr_sel (mem_w_addr_sel),
        .rf_w_en        (rf_w_en),
        .rf_r1_addr_sel (rf_r1_addr_sel),
        .rf_w_addr_sel  (rf_w_addr_sel),
        .rf_w_data_sel  (rf_w_data_sel),
        .ir_ld          (ir_ld),
        .tmp_ld         (tmp_ld),
        .pc_ld          (pc_ld),
        .pc_clr         (pc_clr),
        .pc_inc         (pc_inc),
        .pc_ld_data_sel (pc_ld_data_sel),
        .alu_sel        (alu_sel),
        .cond_ld        (cond_ld),
        .halted         (halted)
`ifdef PUNC_INSTR_CNT_EN
        ,
        .instr_retired  (instr_retired)
`endif
    );

    assign act = {mem_w_en, mem_r_addr_sel, mem_w_addr_sel, rf_w_en, rf_r1_addr_sel,
                  rf_w_addr_sel, rf_w_data_sel, ir_ld, tmp_ld, pc_ld, pc_clr, pc_inc,
                  pc_ld_data_sel, alu_sel, cond_ld, halted};

    // Monitor: pop one expectation per sample point and compare
    initial begin
        item_t it;
        forever begin
            @(negedge clk or sample_ev);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                n_vec++;
                if (act !== it.e) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", it.nm, act, it.e);
                end
            end
        end
    end

    task automatic push(input string nm, input exp_t e);
        item_t it;
        it.nm = nm;
        it.e  = e;
        sb.push_back(it);
    endtask

    // Expect e for the current cycle, then advance to just after the next edge
    task automatic cyc(input string nm, input exp_t e);
        push(nm, e);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t fetch_vec();
        exp_t e = '0;
        e.ir_ld  = 1'b1;
        e.pc_inc = 1'b1;
        return e;
    endfunction

    task automatic run_instr(input string nm, input logic [15:0] instr,
                             input logic nn, input logic zz, input logic pp,
                             input exp_t ex, input bit has2, input exp_t ex2);
        ir = instr; n = nn; z = zz; p = pp;
        cyc({nm, "_fetch"}, fetch_vec());
        cyc({nm, "_decode"}, exp_t'('0));
        cyc({nm, "_exec"}, ex);
        if (has2) cyc({nm, "_exec2"}, ex2);
        exp_retired++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        exp_t e;
        exp_t e2;
        rst = 1'b1; ir = 16'h0000; n = 1'b0; z = 1'b0; p = 1'b0;
        @(posedge clk); #1;
        cyc("reset_a", exp_t'('0));
        cyc("reset_b", exp_t'('0));
        rst = 1'b0;
        e = '0; e.pc_clr = 1'b1;
        cyc("init", e);

        e = '0; e.rf_w_en = 1; e.cond_ld = 1; e.alu_sel = 3'd1;
        run_instr("add_imm", 16'h1261, 0, 0, 0, e, 0, e);
        e = '0; e.rf_w_en = 1; e.cond_ld = 1; e.alu_sel = 3'd0;
        run_instr("add_reg", 16'h1042, 0, 0, 0, e, 0, e);
        e = '0; e.rf_w_en = 1; e.cond_ld = 1; e.alu_sel = 3'd3;
        run_instr("and_imm", 16'h5265, 0, 0, 0, e, 0, e);
        e = '0; e.rf_w_en = 1; e.cond_ld = 1; e.alu_sel = 3'd4;
        run_instr("not", 16'h927F, 0, 0, 0, e, 0, e);
        e = '0; e.pc_ld = 1; e.pc_ld_data_sel = 2'd0;
        run_instr("brz_taken", 16'h0403, 0, 1, 0, e, 0, e);
        e = '0;
        run_instr("brz_not_taken", 16'h0403, 1, 0, 0, e, 0, e);
        run_instr("brnzp_no_flags", 16'h0E00, 0, 0, 0, e, 0, e);
        run_instr("br_mask0", 16'h0000, 1, 1, 1, e, 0, e);
        e = '0; e.pc_ld = 1; e.pc_ld_data_sel = 2'd1;
        run_instr("jmp", 16'hC1C0, 0, 0, 0, e, 0, e);
        e = '0; e.rf_w_en = 1; e.rf_w_addr_sel = 1; e.rf_w_data_sel = 2'd2;
        e.pc_ld = 1; e.pc_ld_data_sel = 2'd2;
        run_instr("jsr", 16'h4FFF, 0, 0, 0, e, 0, e);
        e.pc_ld_data_sel = 2'd1;
        run_instr("jsrr_r7", 16'h41C0, 0, 0, 0, e, 0, e);
        e = '0; e.mem_r_addr_sel = 2'd1; e.rf_w_data_sel = 2'd1; e.rf_w_en = 1; e.cond_ld = 1;
        run_instr("ld", 16'h2205, 0, 0, 0, e, 0, e);
        e.mem_r_addr_sel = 2'd2;
        run_instr("ldr", 16'h6441, 0, 0, 0, e, 0, e);
        e = '0; e.rf_w_data_sel = 2'd3; e.rf_w_en = 1; e.cond_ld = 1;
        run_instr("lea", 16'hE005, 0, 0, 0, e, 0, e);
        e = '0; e.mem_w_en = 1; e.rf_r1_addr_sel = 1; e.mem_w_addr_sel = 2'd0;
        run_instr("st", 16'h3000, 0, 0, 0, e, 0, e);
        e.mem_w_addr_sel = 2'd1;
        run_instr("str", 16'h7041, 0, 0, 0, e, 0, e);
        e = '0; e.mem_r_addr_sel = 2'd1; e.tmp_ld = 1;
        e2 = '0; e2.mem_r_addr_sel = 2'd3; e2.rf_w_data_sel = 2'd1; e2.rf_w_en = 1; e2.cond_ld = 1;
        run_instr("ldi", 16'hA402, 0, 0, 0, e, 1, e2);
        e2 = '0; e2.mem_w_addr_sel = 2'd2; e2.mem_w_en = 1; e2.rf_r1_addr_sel = 1;
        run_instr("sti", 16'hB402, 0, 0, 0, e, 1, e2);
        e = '0;
        run_instr("reserved8", 16'h8000, 0, 0, 0, e, 0, e);
        run_instr("reservedD", 16'hD000, 0, 0, 0, e, 0, e);

        // HALT: terminal, never fetches again
        ir = 16'hF025;
        cyc("halt_fetch", fetch_vec());
        cyc("halt_decode", exp_t'('0));
        e = '0; e.halted = 1;
        for (int i = 0; i < 20; i++) cyc("halt_hold", e);

`ifdef PUNC_INSTR_CNT_EN
        n_vec++;
        if (instr_retired !== 32'(exp_retired)) begin
            n_err++;
            $display("FAIL instr_retired: got %0d expected %0d", instr_retired, exp_retired);
        end
`endif

        // Leave HALT via reset, then reset in the middle of a store
        rst = 1'b1;
        cyc("halt_reset", exp_t'('0));
        rst = 1'b0;
        exp_retired = 0;
        e = '0; e.pc_clr = 1'b1;
        cyc("init2", e);
        ir = 16'h3000;
        cyc("st2_fetch", fetch_vec());
        cyc("st2_decode", exp_t'('0));
        e = '0; e.mem_w_en = 1; e.rf_r1_addr_sel = 1;
        push("st2_exec", e);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        push("st2_reset_mid", exp_t'('0));
        -> sample_ev;
        @(posedge clk); #1;
        cyc("st2_reset_hold", exp_t'('0));
        rst = 1'b0;
        e = '0; e.pc_clr = 1'b1;
        cyc("init3", e);
        cyc("fetch3", fetch_vec());

`ifdef PUNC_INSTR_CNT_EN
        n_vec++;
        if (instr_retired !== 32'(exp_retired)) begin
            n_err++;
            $display("FAIL instr_retired_after_rst: got %0d expected %0d", instr_retired, exp_retired);
        end
`endif

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
